// File: rtl/seq_player_if.sv
// Bus bundle for seq_player: play control, sequence-memory write port
// and the LED/status outputs. The testbench drives the master side.
interface seq_player_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic [SIZE-1:0] level;
    logic            seq_load;
    logic [SIZE-1:0] seq_addr;
    logic [1:0]      seq_color;
    logic [3:0]      led;
    logic [SIZE-1:0] idx;
    logic            busy;
    logic            end_play;

    modport master (
        output start, level, seq_load, seq_addr, seq_color,
        input  led, idx, busy, end_play
    );

    modport slave (
        input  start, level, seq_load, seq_addr, seq_color,
        output led, idx, busy, end_play
    );
endinterface

// File: rtl/seq_player.sv
// Colour-sequence player: plays entries 0..level of a small colour memory
// as timed LED flashes (lit ON_CYCLES, dark OFF_CYCLES per step), then
// emits a one-cycle end_play pulse. Memory is writable only while idle.
module seq_player #(
    parameter int SIZE       = 4,
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4
) (
    input logic          clk,
    input logic          R,
    seq_player_if.slave  bus
);
    localparam int DEPTH = 1 << SIZE;
    localparam int MAXC  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]      state_r;
    logic [CW-1:0]   cnt_r;
    logic [SIZE-1:0] idx_r;
    logic [SIZE-1:0] level_r;
    logic [1:0]      mem_r [DEPTH];
    logic [3:0]      led_s;

    // One-hot LED code for a 2-bit colour.
    function automatic logic [3:0] decode_color(input logic [1:0] color);
        logic [3:0] onehot;
        case (color)
            2'b00:   onehot = 4'b0001;
            2'b01:   onehot = 4'b0010;
            2'b10:   onehot = 4'b0100;
            2'b11:   onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    // Sequence memory: cleared by reset, written only while idle so a
    // running sequence can never be altered underneath the player.
    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else if (bus.seq_load && (state_r == ST_IDLE)) begin
            mem_r[bus.seq_addr] <= bus.seq_color;
        end
    end

    // Playback FSM with a down-counting phase timer; idx stops at level_r
    // and is held through DONE and IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (R) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= {SIZE{1'b0}};
            level_r <= {SIZE{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        level_r <= bus.level;
                        idx_r   <= {SIZE{1'b0}};
                        cnt_r   <= ON_LOAD;
                        state_r <= ST_ON;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r   <= OFF_LOAD;
                        state_r <= ST_OFF;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                ST_OFF: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r   <= cnt_r - CW'(1);
                    end else if (idx_r == level_r) begin
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + SIZE'(1);
                        cnt_r   <= ON_LOAD;
                        state_r <= ST_ON;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // LED drive: lit only during ON, read straight from memory so a write
    // on the start edge is already visible in the first ON cycle.
    always_comb begin
        led_s = 4'b0000;
        if (state_r == ST_ON) begin
            led_s = decode_color(mem_r[idx_r]);
        end else begin
            led_s = 4'b0000;
        end
    end

    assign bus.led      = led_s;
    assign bus.idx      = idx_r;
    assign bus.busy     = (state_r != ST_IDLE);
    assign bus.end_play = (state_r == ST_DONE);
endmodule

// File: tb/tb_seq_player.sv
// Directed testbench for seq_player (SIZE=4, ON=8, OFF=4).
module tb_seq_player;
    localparam int ON_C  = 8;
    localparam int OFF_C = 4;
    localparam int STEP  = ON_C + OFF_C;

    logic clk;
    logic R;
    int   checks_total;
    int   checks_passed;
    logic [1:0] mem_m [16];

    seq_player_if #(.SIZE(4)) bus_if ();

    seq_player #(.SIZE(4), .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic logic [3:0] dec(input logic [1:0] c);
        logic [3:0] tbl [4];
        tbl[0] = 4'b0001; tbl[1] = 4'b0010; tbl[2] = 4'b0100; tbl[3] = 4'b1000;
        return tbl[c];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [1:0] color);
        bus_if.seq_load  = 1'b1;
        bus_if.seq_addr  = addr;
        bus_if.seq_color = color;
        tick();
        bus_if.seq_load  = 1'b0;
        mem_m[addr]      = color;
    endtask

    // Start a run at lvl and follow it to the end, comparing every cycle
    // against the model; inj >= 0 injects start/seq_load/level at that cycle.
    task automatic play(input string tag, input logic [3:0] lvl, input int inj);
        int c, led_errs, end_errs, ends, step, phase;
        logic [3:0] exp_led;
        logic       exp_end;
        bus_if.level = lvl;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        c = 0; led_errs = 0; end_errs = 0; ends = 0;
        while (bus_if.busy && c < 400) begin
            step  = c / STEP;
            phase = c % STEP;
            if (step <= int'(lvl)) begin
                exp_led = (phase < ON_C) ? dec(mem_m[step]) : 4'b0000;
                exp_end = 1'b0;
            end else begin
                exp_led = 4'b0000;
                exp_end = 1'b1;
            end
            if (bus_if.led !== exp_led) led_errs++;
            if (bus_if.end_play !== exp_end) end_errs++;
            if (bus_if.end_play === 1'b1) ends++;
            if (c == inj) begin
                bus_if.start = 1'b1; bus_if.seq_load = 1'b1;
                bus_if.seq_addr = 4'd1; bus_if.seq_color = 2'b11; bus_if.level = 4'd0;
            end else begin
                bus_if.start = 1'b0; bus_if.seq_load = 1'b0;
            end
            c++;
            tick();
        end
        bus_if.start = 1'b0;
        bus_if.seq_load = 1'b0;
        check({tag, "_busy_cycles"}, 32'(c), 32'((int'(lvl) + 1) * STEP + 1));
        check({tag, "_led_errs"}, 32'(led_errs), 32'd0);
        check({tag, "_end_errs"}, 32'(end_errs), 32'd0);
        check({tag, "_end_pulses"}, 32'(ends), 32'd1);
        check({tag, "_idx_hold"}, 32'(bus_if.idx), 32'(lvl));
    endtask

    initial begin
        int ends;
        checks_total = 0;
        checks_passed = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 2'b00;
        bus_if.start = 1'b0; bus_if.level = 4'd0; bus_if.seq_load = 1'b0;
        bus_if.seq_addr = 4'd0; bus_if.seq_color = 2'b00;

        // Reset for two cycles
        R = 1'b1;
        tick(); tick();
        R = 1'b0;
        check("rst_led", 32'(bus_if.led), 32'd0);
        check("rst_idx", 32'(bus_if.idx), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_end", 32'(bus_if.end_play), 32'd0);

        // Idle without start stays idle
        tick(); tick(); tick();
        check("idle_busy", 32'(bus_if.busy), 32'd0);

        // Read-out of cleared memory: every step 0001
        play("readout", 4'd15, -1);

        // Single step
        load(4'd0, 2'b10);
        play("single", 4'd0, -1);

        // Full depth, colours cycling
        for (int i = 0; i < 16; i++) load(4'(i), 2'(i % 4));
        play("full", 4'd15, -1);

        // Start/load/level changes while busy are ignored
        play("ignore", 4'd3, 20);
        play("ignore_rerun", 4'd3, -1);

        // Reset in the 3rd ON cycle of step 2
        bus_if.level = 4'd15;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        ends = 0;
        for (int c = 0; c < 2 * STEP + 2; c++) begin
            if (bus_if.end_play === 1'b1) ends++;
            tick();
        end
        check("abort_pre_led", 32'(bus_if.led), 32'(dec(mem_m[2])));
        check("abort_pre_idx", 32'(bus_if.idx), 32'd2);
        R = 1'b1;
        tick();
        R = 1'b0;
        check("abort_led", 32'(bus_if.led), 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_idx", 32'(bus_if.idx), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (bus_if.end_play === 1'b1) ends++;
            tick();
        end
        check("abort_no_end", 32'(ends), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[i] = 2'b00;
        play("post_abort", 4'd15, -1);

        // Same-edge load and start
        bus_if.seq_load = 1'b1; bus_if.seq_addr = 4'd0; bus_if.seq_color = 2'b11;
        bus_if.level = 4'd0; bus_if.start = 1'b1;
        tick();
        bus_if.seq_load = 1'b0; bus_if.start = 1'b0;
        mem_m[0] = 2'b11;
        check("same_edge_led", 32'(bus_if.led), 32'b1000);
        ends = 0;
        for (int c = 0; c < 40 && bus_if.busy; c++) begin
            if (bus_if.end_play === 1'b1) ends++;
            tick();
        end
        check("same_edge_end", 32'(ends), 32'd1);
        check("same_edge_idle", 32'(bus_if.busy), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 Parameter SIZE, default 4, is the width of the step index and the level; the sequence depth is 2^SIZE.
REQ-002 Parameter ON_CYCLES, default 8, is the number of clocks an LED stays lit per step (>=1).
REQ-003 Parameter OFF_CYCLES, default 4, is the number of dark clocks after each lit step (>=1).
REQ-004 Port clk  in  1  is the single clock; all state changes on its rising edge.
REQ-005 Port R  in  1  is the reset, synchronous and active-high.
REQ-006 Port start  in  1  is a play request, sampled only in IDLE.
REQ-007 Port level  in  SIZE  is the index of the last step to play, sampled with start.
REQ-008 Port seq_load  in  1  is the sequence-memory write enable.
REQ-009 Port seq_addr  in  SIZE  is the sequence-memory write address.
REQ-010 Port seq_color  in  2  is the sequence-memory write data (colour code).
REQ-011 Port led  out  4  is the one-hot LED drive; all zero when dark.
REQ-012 Port idx  out  SIZE  is the step currently being played.
REQ-013 Port busy  out  1  is high from the first ON cycle through the DONE cycle.
REQ-014 Port end_play  out  1  is a one-cycle pulse marking completion; it feeds the user-input counter stage as its enable.

Function
REQ-015 Memory: 2^SIZE entries x 2 bits; one write per clock when seq_load=1 and state=IDLE; writes in any other state are discarded.
REQ-016 Colour decode: 00->led=0001, 01->0010, 10->0100, 11->1000.
REQ-017 FSM states: IDLE, ON, OFF, DONE.
REQ-018 IDLE: on start=1, latch level into level_q, set idx=0, load the phase counter, go to ON next cycle; start=0 stays IDLE.
REQ-019 ON: led = decode(mem[idx]) (combinational from registered state, idx and memory); lasts exactly ON_CYCLES cycles, then OFF.
REQ-020 OFF: led=0000; lasts exactly OFF_CYCLES cycles; at its end, idx==level_q -> DONE, else idx<=idx+1 and go to ON.
REQ-021 DONE: lasts one cycle; end_play=1, busy=1, led=0000; then IDLE.
REQ-022 Total busy time per run = (level_q+1)*(ON_CYCLES+OFF_CYCLES)+1 cycles.
REQ-023 idx never wraps: level=2^SIZE-1 plays every entry; idx holds its last value in DONE and IDLE until the next start.
REQ-024 start while busy=1 is ignored and not queued; level changes while busy have no effect.
REQ-025 Same-edge seq_load and start in IDLE: the write completes, and the written value is visible in the first ON cycle.
REQ-026 end_play never asserts outside DONE; exactly one pulse per accepted start.

Reset
REQ-027 R=1 at a rising edge forces, from the next cycle: state=IDLE, idx=0, level_q=0, phase counter=0, led=0000, busy=0, end_play=0, all memory entries=00.
REQ-028 R overrides start, seq_load and any in-progress run; a run aborted by reset produces no end_play.

Verification
REQ-029 Reset: R=1 for 2 cycles, then drop it -> led=0000, idx=0, busy=0, end_play=0; a read-out run at level=15 shows led=0001 on every step.
REQ-030 Single step: load mem[0]=10, level=0, pulse start -> led=0100 for 8 cycles, then 0000 for 4, then end_play=1 for one cycle; busy high for 13 cycles.
REQ-031 Full depth: load mem[i]=i mod 4, level=15, start -> 16 flashes cycling 0001,0010,0100,1000; busy 193 cycles; idx stops at 15; one end_play.
REQ-032 Ignore while busy: start and seq_load (addr 1, data 11) mid-run at level=3 -> run still ends after 49 cycles; mem[1] unchanged on the next run.
REQ-033 Reset mid-run: R=1 in the 3rd ON cycle of step 2 -> next cycle led=0000, busy=0, idx=0; no end_play; memory reads all 00 afterwards.
REQ-034 Same-edge load/start: seq_load addr0 data 11 together with start, level=0 -> the first ON cycle shows led=1000.
